// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : wb_queue
//  Description : Writeback queue between the pipeline and the register file.
//                Buffers {register, data} writebacks in a circular FIFO,
//                drains one entry per cycle unless the write port is held,
//                and forwards the newest pending value for two lookup
//                addresses. Register 0 requests are consumed and dropped.
//                Optional feature: define WBQ_COALESCE_EN to merge a push
//                into the newest pending entry for the same register.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [4:0]               in_reg,
    input  logic [31:0]              in_data,
    output logic                     in_ready,
    input  logic                     wr_hold,
    output logic                     regWrite,
    output logic [4:0]               writeRegister,
    output logic [31:0]              writeData,
    input  logic [4:0]               lookupReg1,
    input  logic [4:0]               lookupReg2,
    output logic                     fwdHit1,
    output logic                     fwdHit2,
    output logic [31:0]              fwdData1,
    output logic [31:0]              fwdData2,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL  = c_LVL_W'(DEPTH);

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_LVL_W-1:0] r_level;
    logic [4:0]         r_entryReg  [DEPTH];
    logic [31:0]        r_entryData [DEPTH];

    logic [c_PTR_W-1:0] w_slot [DEPTH];
    logic [DEPTH-1:0]   w_occ;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_accept;
    logic               w_writeEntry;
    logic               w_alloc;
    logic               w_coalesceMatch;
    logic               w_hit1;
    logic               w_hit2;
    logic [c_PTR_W-1:0] w_sel1;
    logic [c_PTR_W-1:0] w_sel2;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL);

    // Slot k holds the k-th oldest entry; it is live when k < level
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_slot[k] = r_head + c_PTR_W'(k);
            w_occ[k]  = (c_LVL_W'(k) < r_level);
        end
    end

    // Forwarding search, oldest to newest so the newest match wins
    always_comb begin
        w_hit1 = 1'b0;
        w_sel1 = '0;
        w_hit2 = 1'b0;
        w_sel2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_occ[k] && (lookupReg1 != 5'd0) && (r_entryReg[w_slot[k]] == lookupReg1)) begin
                w_hit1 = 1'b1;
                w_sel1 = w_slot[k];
            end
            if (w_occ[k] && (lookupReg2 != 5'd0) && (r_entryReg[w_slot[k]] == lookupReg2)) begin
                w_hit2 = 1'b1;
                w_sel2 = w_slot[k];
            end
        end
    end

`ifdef WBQ_COALESCE_EN
    logic               w_cHit;
    logic [c_PTR_W-1:0] w_cSel;
    logic               w_merge;

    // Newest pending entry targeting the incoming register
    always_comb begin
        w_cHit = 1'b0;
        w_cSel = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_occ[k] && (r_entryReg[w_slot[k]] == in_reg)) begin
                w_cHit = 1'b1;
                w_cSel = w_slot[k];
            end
        end
    end

    // A head leaving this cycle cannot absorb the write; allocate instead
    assign w_coalesceMatch = w_cHit && (in_reg != 5'd0) && !(w_pop && (w_cSel == r_head));
    assign in_ready        = !w_full || w_coalesceMatch;
    assign w_merge         = w_writeEntry && w_coalesceMatch;
`else
    assign w_coalesceMatch = 1'b0;
    assign in_ready        = !w_full;
`endif

    // A pop frees no slot for a same-cycle push: ready depends on level only
    assign w_accept     = in_valid && in_ready;
    assign w_writeEntry = w_accept && (in_reg != 5'd0);
    assign w_alloc      = w_writeEntry && !w_coalesceMatch;
    assign w_pop        = !w_empty && !wr_hold;

    // Entry storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge clock) begin
        if (w_alloc) begin
            r_entryReg[r_tail]  <= in_reg;
            r_entryData[r_tail] <= in_data;
        end
`ifdef WBQ_COALESCE_EN
        else if (w_merge) begin
            r_entryData[w_cSel] <= in_data;
        end
`endif
    end

    // Pointer and occupancy bookkeeping, cleared asynchronously
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_alloc, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Register-file write port and forwarding outputs
    always_comb begin
        regWrite      = w_pop;
        writeRegister = w_empty ? 5'd0  : r_entryReg[r_head];
        writeData     = w_empty ? 32'd0 : r_entryData[r_head];
        fwdHit1       = w_hit1;
        fwdHit2       = w_hit2;
        fwdData1      = w_hit1 ? r_entryData[w_sel1] : 32'd0;
        fwdData2      = w_hit2 ? r_entryData[w_sel2] : 32'd0;
        level         = r_level;
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_queue
//  Description : Directed self-checking bench for wb_queue (DEPTH = 4).
//                Expected level after a same-register double push depends
//                on whether WBQ_COALESCE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_queue;

    localparam int DEPTH = 4;

    logic        clock;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wr_hold;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [4:0]  lookupReg1;
    logic [4:0]  lookupReg2;
    logic        fwdHit1;
    logic        fwdHit2;
    logic [31:0] fwdData1;
    logic [31:0] fwdData2;
    logic [$clog2(DEPTH):0] level;

    int nTests = 0;
    int nFail  = 0;

    logic [4:0]  qReg [$];
    logic [31:0] qData [$];

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_reg        (in_reg),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .wr_hold       (wr_hold),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .lookupReg1    (lookupReg1),
        .lookupReg2    (lookupReg2),
        .fwdHit1       (fwdHit1),
        .fwdHit2       (fwdHit2),
        .fwdData1      (fwdData1),
        .fwdData2      (fwdData2),
        .level         (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_reg     = 5'd0;
        in_data    = 32'd0;
        wr_hold    = 1'b0;
        lookupReg1 = 5'd0;
        lookupReg2 = 5'd0;

        // Reset state
        #3;
        checkVal("rst_level",    32'(level), 32'd0);
        checkVal("rst_regWrite", 32'(regWrite), 32'd0);
        checkVal("rst_in_ready", 32'(in_ready), 32'd1);
        checkVal("rst_wdata",    writeData, 32'd0);
        checkVal("rst_fwdHit1",  32'(fwdHit1), 32'd0);
        tick();
        rst = 1'b1;

        // Single push, one cycle latency, not forwarded in its own cycle
        in_valid = 1'b1; in_reg = 5'd3; in_data = 32'h11; lookupReg1 = 5'd3;
        #1;
        checkVal("lat_noWriteSame", 32'(regWrite), 32'd0);
        checkVal("lat_noFwdSame",   32'(fwdHit1), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        checkVal("lat_regWrite", 32'(regWrite), 32'd1);
        checkVal("lat_wreg",     32'(writeRegister), 32'd3);
        checkVal("lat_wdata",    writeData, 32'h11);
        checkVal("lat_fwdHead",  32'(fwdHit1), 32'd1);
        checkVal("lat_fwdData",  fwdData1, 32'h11);
        tick();
        checkVal("lat_levelAfter", 32'(level), 32'd0);
        checkVal("lat_idle",       32'(regWrite), 32'd0);

        // Fill under hold, fifth push refused, then ordered drain
        wr_hold = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_reg = 5'(i); in_data = 32'h100 + 32'(i);
            #1;
            checkVal($sformatf("fill_ready%0d", i), 32'(in_ready), (i <= 4) ? 32'd1 : 32'd0);
            checkVal($sformatf("fill_noPop%0d", i), 32'(regWrite), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        checkVal("fill_level", 32'(level), 32'd4);
        wr_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checkVal($sformatf("drain_we%0d", i),   32'(regWrite), 32'd1);
            checkVal($sformatf("drain_reg%0d", i),  32'(writeRegister), 32'(i));
            checkVal($sformatf("drain_data%0d", i), writeData, 32'h100 + 32'(i));
            tick();
        end
        checkVal("drain_level", 32'(level), 32'd0);

        // Same register twice under hold: forward the newest value
        wr_hold = 1'b1; lookupReg1 = 5'd7; lookupReg2 = 5'd9;
        in_valid = 1'b1; in_reg = 5'd7; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        #1;
        checkVal("fwd_hit",     32'(fwdHit1), 32'd1);
        checkVal("fwd_data",    fwdData1, 32'hB);
        checkVal("fwd_missHit", 32'(fwdHit2), 32'd0);
        checkVal("fwd_missDat", fwdData2, 32'd0);
`ifdef WBQ_COALESCE_EN
        checkVal("fwd_level", 32'(level), 32'd1);
`else
        checkVal("fwd_level", 32'(level), 32'd2);
`endif
        wr_hold = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        checkVal("fwd_drained", 32'(level), 32'd0);

        // Register 0 request is consumed and dropped
        in_valid = 1'b1; in_reg = 5'd0; in_data = 32'h55; lookupReg2 = 5'd0;
        #1;
        checkVal("r0_ready",  32'(in_ready), 32'd1);
        checkVal("r0_fwdHit", 32'(fwdHit2), 32'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkVal($sformatf("r0_noWrite%0d", i), 32'(regWrite), 32'd0);
            checkVal($sformatf("r0_level%0d", i),   32'(level), 32'd0);
            tick();
        end

        // Asynchronous reset mid-cycle discards pending entries
        wr_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_reg = 5'(10 + i); in_data = 32'h200 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        checkVal("ar_levelPre", 32'(level), 32'd3);
        #2;
        rst = 1'b0; wr_hold = 1'b0;
        #1;
        checkVal("ar_level",    32'(level), 32'd0);
        checkVal("ar_regWrite", 32'(regWrite), 32'd0);
        checkVal("ar_wreg",     32'(writeRegister), 32'd0);
        checkVal("ar_wdata",    writeData, 32'd0);
        checkVal("ar_ready",    32'(in_ready), 32'd1);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkVal($sformatf("ar_noWrite%0d", i), 32'(regWrite), 32'd0);
            tick();
        end

        // Steady push+pop at level 2 through three pointer laps
        wr_hold = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            in_valid = 1'b1; in_reg = 5'(i); in_data = 32'h300 + 32'(i);
            qReg.push_back(5'(i)); qData.push_back(32'h300 + 32'(i));
            tick();
        end
        wr_hold = 1'b0;
        for (int n = 0; n < 3 * DEPTH; n++) begin
            in_valid = 1'b1; in_reg = 5'(n + 3); in_data = 32'h400 + 32'(n);
            #1;
            checkVal($sformatf("lap_we%0d", n),    32'(regWrite), 32'd1);
            checkVal($sformatf("lap_reg%0d", n),   32'(writeRegister), 32'(qReg[0]));
            checkVal($sformatf("lap_data%0d", n),  writeData, qData[0]);
            checkVal($sformatf("lap_level%0d", n), 32'(level), 32'd2);
            tick();
            void'(qReg.pop_front()); void'(qData.pop_front());
            qReg.push_back(5'(n + 3)); qData.push_back(32'h400 + 32'(n));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checkVal($sformatf("lapDrain_reg%0d", i),  32'(writeRegister), 32'(qReg[0]));
            checkVal($sformatf("lapDrain_data%0d", i), writeData, qData[0]);
            tick();
            void'(qReg.pop_front()); void'(qData.pop_front());
        end
        checkVal("lap_levelEnd", 32'(level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
